mmio_uart_tx: RTL

- Memory-mapped UART transmitter that sits on the far side of the core's MMIO ports.
- Consumes one core output word (a command register) and drives one core input word (a status register).
- Software pushes bytes into a FIFO using a toggle handshake, because MMIO provides no write strobe.
- The block serialises FIFO bytes onto a single 8N1 line.

---
 rtl/mmio_uart_tx_if.sv | 26 ++
 rtl/mmio_uart_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx_if.sv
// Bus bundle between the core's MMIO words and the UART transmitter.
// txCommand is one mmioOutputs word and txStatus the matching mmioInputs word.
// Push handshake: software flips txCommand[31] while placing a byte in [7:0].
// The transmitter echoes the flipped value on txStatus[31] on the same edge that sees the flip.
// Software then polls txStatus[31] until it matches.
// There is no valid/ready pair because MMIO carries no strobes.
interface mmio_uart_tx_if;
    logic [31:0] txCommand;
    logic [31:0] txStatus;
    logic        uartTx;
    logic [1:0]  dbg_state;

    modport master (
        output txCommand,
        input  txStatus,
        input  uartTx,
        input  dbg_state
    );

    modport slave (
        input  txCommand,
        output txStatus,
        output uartTx,
        output dbg_state
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a toggle-handshake byte FIFO.
// Bytes pushed by software are serialised LSB first.
// Back-to-back frames are sent when the FIFO is not empty at the end of a stop bit.
module mmio_uart_tx #(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic          clock,
    input  logic          reset,
    mmio_uart_tx_if.slave bus
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(CLOCKS_PER_BIT);

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Handshake and FIFO bookkeeping
    logic          r_prev_toggle;
    logic          r_ack_toggle;
    logic          r_overflow;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_mem [DEPTH];

    // Serialiser
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shifter;
    logic          r_uart_tx;

    // Combinational next-state values
    state_t        w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [2:0]    w_bit_idx_nxt;
    logic [7:0]    w_shifter_nxt;
    logic          w_uart_tx_nxt;
    logic          w_pop;

    logic          w_push;
    logic          w_push_accept;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic          w_timer_last;
    logic [2:0]    w_bit_idx_inc;
    logic [31:0]   w_status;
    logic          w_unused_cmd;

    assign w_push        = (bus.txCommand[31] != r_prev_toggle);
    assign w_full        = (r_count == COUNT_FULL);
    assign w_empty       = (r_count == '0);
    // A push into a full FIFO still fits when the serialiser pops on the same edge.
    assign w_push_accept = w_push && (!w_full || w_pop);
    assign w_drop        = w_push && w_full && !w_pop;
    assign w_timer_last  = (r_timer == TIMER_LAST);
    assign w_bit_idx_inc = r_bit_idx + 3'd1;
    assign w_unused_cmd  = ^bus.txCommand[30:8];

    // Toggle tracking, FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_toggle <= bus.txCommand[31];
            r_ack_toggle  <= bus.txCommand[31];
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) begin
                r_prev_toggle <= bus.txCommand[31];
                r_ack_toggle  <= bus.txCommand[31];
            end
            if (w_push_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case ({w_push_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clock) begin
        if (!reset && w_push_accept) begin
            r_mem[r_wr_ptr] <= bus.txCommand[7:0];
        end
    end

    // Serialiser registers, including the registered line output
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shifter <= '0;
            r_uart_tx <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shifter <= w_shifter_nxt;
            r_uart_tx <= w_uart_tx_nxt;
        end
    end

    // Frame sequencing; the line value for the next state is chosen on each transition
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_idx_nxt = r_bit_idx;
        w_shifter_nxt = r_shifter;
        w_uart_tx_nxt = r_uart_tx;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_uart_tx_nxt = 1'b1;
                w_timer_nxt   = '0;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shifter_nxt = r_mem[r_rd_ptr];
                    w_state_nxt   = S_START;
                    w_uart_tx_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_timer_last) begin
                    w_timer_nxt   = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = S_DATA;
                    w_uart_tx_nxt = r_shifter[0];
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_DATA: begin
                if (w_timer_last) begin
                    w_timer_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt   = S_STOP;
                        w_uart_tx_nxt = 1'b1;
                    end else begin
                        w_bit_idx_nxt = w_bit_idx_inc;
                        w_uart_tx_nxt = r_shifter[w_bit_idx_inc];
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_STOP: begin
                if (w_timer_last) begin
                    w_timer_nxt = '0;
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_shifter_nxt = r_mem[r_rd_ptr];
                        w_state_nxt   = S_START;
                        w_uart_tx_nxt = 1'b0;
                    end else begin
                        w_state_nxt   = S_IDLE;
                        w_uart_tx_nxt = 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_uart_tx_nxt = 1'b1;
            end
        endcase
    end

    // Status word assembled from registers only
    always_comb begin
        w_status         = '0;
        w_status[31]     = r_ack_toggle;
        w_status[30]     = w_full;
        w_status[29]     = w_empty;
        w_status[28]     = (r_state != S_IDLE) || !w_empty;
        w_status[27]     = r_overflow;
        w_status[CW-1:0] = r_count;
    end

    assign bus.txStatus  = w_status;
    assign bus.uartTx    = r_uart_tx;
    assign bus.dbg_state = r_state;

endmodule
